// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sync transmitter and its detector.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSync    = 2'd1,
    StPayload = 2'd2,
    StGap     = 2'd3
  } seq_state_e;

  // Sync word shared with the downstream pattern detector, sent MSB first.
  localparam logic [4:0]  SYNC_PATTERN_DEFAULT = 5'b10010;
  localparam int unsigned SYNC_LEN_DEFAULT     = 5;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first parallel-in / serial-out shift register for the payload.
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic              sout
);

  logic [DATA_W-1:0] sreg_q;

  // Load wins over shift; the MSB is always the next bit to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift_en) begin
      sreg_q <= sreg_q << 1;
    end
  end

  assign sout = sreg_q[DATA_W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, then forced-zero gap.
module seq_tx
  import seq_pkg::*;
#(
  parameter int unsigned          PAT_LEN    = SYNC_LEN_DEFAULT,
  parameter logic [PAT_LEN-1:0]   PATTERN    = SYNC_PATTERN_DEFAULT,
  parameter int unsigned          DATA_W     = 8,
  parameter int unsigned          GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MaxLen  = max2(max2(PAT_LEN, DATA_W), max2(GAP_CYCLES, 1));
  localparam int unsigned CntW    = $clog2(MaxLen) + 1;
  localparam int unsigned GapLen  = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  localparam logic [CntW-1:0] SyncLast = CntW'(PAT_LEN - 1);
  localparam logic [CntW-1:0] PayLast  = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapLen - 1);

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              data_out_q, data_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, shift_en, sout;
  logic [PAT_LEN-1:0] pat_next;

  seq_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .din      (data_in),
    .sout     (sout)
  );

  // Next state and next registered outputs; cnt_q indexes the bit currently on the line.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_out_d  = 1'b0;
    bit_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    // Align the next sync bit to the MSB so no variable-width index is needed.
    pat_next    = PATTERN << (cnt_q + 1'b1);

    case (state_q)
      StIdle: begin
        if (start) begin
          load        = 1'b1;
          state_d     = StSync;
          cnt_d       = '0;
          data_out_d  = PATTERN[PAT_LEN-1];
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      StSync: begin
        bit_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (cnt_q == SyncLast) begin
          state_d    = StPayload;
          cnt_d      = '0;
          data_out_d = sout;
          shift_en   = 1'b1;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          data_out_d = pat_next[PAT_LEN-1];
        end
      end

      StPayload: begin
        if (cnt_q == PayLast) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
            busy_d  = 1'b1;
          end
        end else begin
          cnt_d       = cnt_q + 1'b1;
          data_out_d  = sout;
          shift_en    = 1'b1;
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and all outputs are registered; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_out_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_out  = data_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: stimulus pushes expected bits, monitors pop and compare.
module tb_seq_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [7:0] data_in, data_in2;
  logic       data_out, bit_valid, busy, done;
  logic       data_out2, bit_valid2, busy2, done2;

  always #5 clk = ~clk;

  seq_tx #(
    .PAT_LEN    (5),
    .PATTERN    (5'b10010),
    .DATA_W     (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .data_out  (data_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  seq_tx #(
    .PAT_LEN    (5),
    .PATTERN    (5'b10010),
    .DATA_W     (8),
    .GAP_CYCLES (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .data_in   (data_in2),
    .data_out  (data_out2),
    .bit_valid (bit_valid2),
    .busy      (busy2),
    .done      (done2)
  );

  localparam logic [4:0] Pat = 5'b10010;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  int exp_frames  = 0;
  int done_cnt    = 0;
  int exp_frames2 = 0;
  int done_cnt2   = 0;
  int det_cnt     = 0;
  bit det_en      = 1'b0;
  bit b2b_flag    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 4; i >= 0; i--) exp_q.push_back(Pat[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    exp_frames++;
  endtask

  // Monitor for the GAP_CYCLES=2 instance: bit scoreboard, frame timing, detector model.
  initial begin : mon_main
    int busy_run = 0;
    int valid_run = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic prev_valid = 1'b0;
    logic [4:0] hist = '0;
    bit e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {28'd0, data_out, bit_valid, busy, done}, 32'd0);
        busy_run = 0; valid_run = 0; hist = '0;
        prev_busy = 1'b0; prev_done = 1'b0; prev_valid = 1'b0;
      end else begin
        if (bit_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("serial_bit", {31'd0, data_out}, {31'd0, e});
          end
        end else if (data_out) begin
          check("zero_when_not_valid", {31'd0, data_out}, 32'd0);
        end
        if (bit_valid && !prev_valid && b2b_flag) begin
          check("b2b_sync_after_done", {31'd0, prev_done}, 32'd1);
          b2b_flag = 1'b0;
        end
        if (bit_valid) valid_run++;
        else if (valid_run != 0) begin
          check("bit_valid_len", valid_run, 32'd13);
          valid_run = 0;
        end
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          check("busy_len", busy_run, 32'd15);
          check("done_at_busy_fall", {31'd0, done}, 32'd1);
          busy_run = 0;
        end
        if (done) begin
          done_cnt++;
          check("done_follows_busy", {31'd0, prev_busy}, 32'd1);
        end
        hist = {hist[3:0], data_out};
        if (det_en && hist == 5'b10010) begin
          det_cnt++;
          check("detect_align_5th_sync", valid_run, 32'd5);
        end
        prev_busy = busy; prev_done = done; prev_valid = bit_valid;
      end
    end
  end

  // Monitor for the GAP_CYCLES=0 instance: frame length only.
  initial begin : mon_gap0
    int busy_run = 0;
    int valid_run = 0;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0; valid_run = 0; prev_busy = 1'b0;
      end else begin
        if (bit_valid2) valid_run++;
        else if (valid_run != 0) begin
          check("gap0_bit_valid_len", valid_run, 32'd13);
          valid_run = 0;
        end
        if (busy2) busy_run++;
        else if (busy_run != 0) begin
          check("gap0_busy_len", busy_run, 32'd13);
          check("gap0_done_at_busy_fall", {31'd0, done2}, 32'd1);
          busy_run = 0;
        end
        if (done2) begin
          done_cnt2++;
          check("gap0_done_follows_busy", {31'd0, prev_busy}, 32'd1);
        end
        prev_busy = busy2;
      end
    end
  end

  // Issue a single-cycle start; returns just after the accepting edge.
  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    start   = 1'b1;
    data_in = d;
    push_frame(d);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; start2 = 1'b0; data_in2 = '0;

    // Test 1: reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {28'd0, data_out, bit_valid, busy, done}, 32'd0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", {28'd0, data_out, bit_valid, busy, done}, 32'd0);
    end

    // Test 2: single frame A5
    send(8'hA5);
    data_in = 8'h5A;
    repeat (17) @(posedge clk);
    check("t2_done_count", done_cnt, exp_frames);
    check("t2_queue_drained", exp_q.size(), 32'd0);

    // Test 3: start held high, 3C then FF back-to-back
    @(posedge clk);
    #1;
    start = 1'b1; data_in = 8'h3C;
    push_frame(8'h3C);
    @(posedge clk);
    #1;
    data_in = 8'hFF;
    repeat (15) @(posedge clk);
    #1;
    push_frame(8'hFF);
    b2b_flag = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    check("t3_done_count", done_cnt, exp_frames);
    check("t3_queue_drained", exp_q.size(), 32'd0);
    check("t3_b2b_seen", {31'd0, b2b_flag}, 32'd0);

    // Test 4: mid-frame starts and data changes are ignored
    send(8'hA5);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; data_in = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    check("t4_done_count", done_cnt, exp_frames);
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // Test 5: async reset during the 7th bit, then a clean frame
    send(8'h55);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_frames--;
    #1;
    check("t5_async_reset", {28'd0, data_out, bit_valid, busy, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_no_done_on_abort", done_cnt, exp_frames);
    send(8'h81);
    repeat (17) @(posedge clk);
    check("t5_done_count", done_cnt, exp_frames);
    check("t5_queue_drained", exp_q.size(), 32'd0);

    // Test 6: detector loopback with zero payload, then GAP_CYCLES=0 instance
    det_en = 1'b1;
    det_cnt = 0;
    repeat (3) begin
      send(8'h00);
      repeat (17) @(posedge clk);
    end
    det_en = 1'b0;
    check("t6_detections", det_cnt, 32'd3);
    check("t6_done_count", done_cnt, exp_frames);

    @(posedge clk);
    #1;
    start2 = 1'b1; data_in2 = 8'h00;
    exp_frames2++;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (16) @(posedge clk);
    check("t6_gap0_done_count", done_cnt2, exp_frames2);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
Serial frame transmitter that produces the bitstream consumed by the downstream serial pattern detector.
- On a start request it emits a fixed sync pattern (default 10010), then a parallel payload word MSB-first, then a run of forced-zero gap bits.
- The gap returns the detector to its idle state before the next frame.
- It sits between a control/data source and the single-bit serial line, one bit per clock.

Parameters:
- PATTERN, 5'b10010, sync pattern, sent MSB first.
- PAT_LEN, 5, number of sync bits (width of PATTERN).
- DATA_W, 8, payload width in bits.
- GAP_CYCLES, 2, forced-zero idle bits after the payload; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- data_in  input  DATA_W  payload; captured on the accepting edge.
- data_out  output  1  serial bit, registered.
- bit_valid  output  1  high while data_out carries a sync or payload bit.
- busy  output  1  high from the accepting edge until the frame (gap included) completes.
- done  output  1  one-cycle pulse when the block returns to IDLE after a frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. While rst=1, data_out=0, bit_valid=0, busy=0, done=0, state=IDLE, counters=0.
- FSM states: IDLE, SYNC, PAYLOAD, GAP. All outputs are registered.
- IDLE:
  - start=1 at edge k: latch data_in into the shift register and go to SYNC.
  - After edge k: data_out=PATTERN[PAT_LEN-1], bit_valid=1, busy=1.
  - start=0: stay in IDLE; data_out=0, bit_valid=0.
- SYNC: output PATTERN[PAT_LEN-1] down to PATTERN[0], one bit per cycle (PAT_LEN cycles), then go to PAYLOAD.
- PAYLOAD: output data[DATA_W-1] down to data[0] (DATA_W cycles), then go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: data_out=0, bit_valid=0, busy=1 for GAP_CYCLES cycles, then go to IDLE.
- Frame timing:
  - busy is high for exactly PAT_LEN+DATA_W+GAP_CYCLES cycles (default 15).
  - bit_valid is high for exactly PAT_LEN+DATA_W cycles (default 13).
- done: high for one cycle, in the first cycle after busy falls (state=IDLE). It coincides with busy=0.
- Back-to-back frames: start=1 during the done cycle is accepted, giving zero idle cycles beyond GAP.
- start while busy is ignored and not queued. data_in changes after capture have no effect on the frame in flight.
- Bit counter width is clog2(max(PAT_LEN, DATA_W, GAP_CYCLES, 1))+1. It clears on each state entry and has no wrap beyond the terminal count.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). No done pulse. The partial frame is abandoned.
- Payload is not bit-stuffed. A payload containing the sync pattern can false-trigger a detector; avoiding that is the source's responsibility.

Decomposition:
- Shared package seq_pkg:
  - state enum (IDLE=0, SYNC=1, PAYLOAD=2, GAP=3, 2-bit encoding);
  - SYNC_PATTERN_DEFAULT=5'b10010, SYNC_LEN_DEFAULT=5.
  - The detector uses the same pattern constant.
- One sub-module, seq_tx_shreg: a loadable MSB-first parallel-in/serial-out shift register (load, shift_en, din[DATA_W-1:0], sout).
  - The FSM and counter stay in seq_tx.

Test Plan:
1. Reset then idle: rst=1 for 3 cycles, release, start=0 for 10 cycles -> data_out=0, bit_valid=0, busy=0, done=0 throughout.
2. Single frame, data_in=8'hA5, start pulse -> data_out sequence 1,0,0,1,0, 1,0,1,0,0,1,0,1, then 0,0.
   - bit_valid high 13 cycles, busy high 15 cycles.
   - done high exactly once, in cycle 16 after the accepting edge.
3. Back-to-back: start held high continuously with data_in=8'h3C then 8'hFF -> second frame's first sync bit appears the cycle after done. Captured payloads are 3C and FF.
4. start pulses and data_in changes (8'h00) mid-frame -> ignored. Frame still carries the originally captured 8'hA5, with no extra done.
5. Reset asserted on the 7th bit of a frame -> outputs go to 0 asynchronously with no done. After release, a start with 8'h81 yields a clean, complete frame.
6. Loopback into the pattern detector, frames with payload 8'h00, GAP_CYCLES=2 -> exactly one detection per frame, aligned to the 5th sync bit. Rerun with GAP_CYCLES=0 and verify busy lasts 13 cycles.
